inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the IF stage and `mem_ctrl`. Serves IF fetch requests in one cycle on a hit. On a miss it drives `mem_ctrl`'s instruction port (`pc_i`/`inst_enable`), waits for the assembled 32-bit word (`inst_o`/`inst_ok`), fills the line and returns the word to IF. A branch redirect (`flush`) abandons an outstanding miss.

---
 rtl/inst_cache_pkg.sv | 19 +
 rtl/inst_cache_store.sv | 47 ++++
 rtl/inst_cache.sv | 114 +++++++++++
 tb/tb_inst_cache.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// reset word and address-slicing constants.
package inst_cache_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam int unsigned INDEX_BITS_DEF = 7;
  // Byte offset within a 32-bit word; these PC bits never select anything.
  localparam int unsigned OFFSET_BITS    = 2;

  function automatic int unsigned tag_lsb(input int unsigned index_bits);
    return index_bits + OFFSET_BITS;
  endfunction

endpackage

// File: rtl/inst_cache_store.sv
// Line storage for inst_cache: valid/tag/data flop arrays with one
// combinational read port and one clocked write port.
module inst_cache_store
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned TAG_W      = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [31:0]           wr_data_i
);

  localparam int unsigned LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Only the valid bits are cleared; tag/data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i && !rst) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache between IF and mem_ctrl.
// One-cycle hit response; misses are filled through mem_ctrl's inst port.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = INDEX_BITS_DEF,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  flush,
  output logic [31:0]           if_inst,
  output logic                  if_ok,
  output logic [ADDR_WIDTH-1:0] mc_pc,
  output logic                  mc_enable,
  input  logic [31:0]           mc_inst,
  input  logic                  mc_ok
);

  localparam int unsigned TAG_LSB = tag_lsb(INDEX_BITS);
  localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;

  state_e                state_q;
  logic                  if_ok_q;
  logic [31:0]           if_inst_q;
  logic                  mc_enable_q;
  logic [ADDR_WIDTH-1:0] mc_pc_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line_data;
  logic                  hit;
  logic                  accept;
  logic                  fill_we;
  logic                  unused_lsbs;

  assign req_idx     = if_pc[TAG_LSB-1:OFFSET_BITS];
  assign req_tag     = if_pc[ADDR_WIDTH-1:TAG_LSB];
  assign unused_lsbs = ^if_pc[OFFSET_BITS-1:0];

  assign hit    = line_valid && (line_tag == req_tag);
  // The cycle showing a response is never an accept cycle, so IF can advance.
  assign accept = if_req && !if_ok_q && !flush;
  // A fill coinciding with flush still lands: the data is right for mc_pc.
  assign fill_we = (state_q == ST_MISS) && mc_ok;

  inst_cache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (req_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (fill_we),
    .wr_idx_i   (mc_pc_q[TAG_LSB-1:OFFSET_BITS]),
    .wr_tag_i   (mc_pc_q[ADDR_WIDTH-1:TAG_LSB]),
    .wr_data_i  (mc_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      if_ok_q     <= 1'b0;
      if_inst_q   <= ZeroWord;
      mc_enable_q <= 1'b0;
      mc_pc_q     <= '0;
    end else begin
      if_ok_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (hit) begin
              if_ok_q   <= 1'b1;
              if_inst_q <= line_data;
            end else begin
              mc_pc_q     <= if_pc;
              mc_enable_q <= 1'b1;
              state_q     <= ST_MISS;
            end
          end
        end
        ST_MISS: begin
          // Every exit drops mc_enable into IDLE, which cannot re-raise it
          // before the next edge, so mem_ctrl always sees one idle cycle.
          if (mc_ok) begin
            mc_enable_q <= 1'b0;
            state_q     <= ST_IDLE;
            if (!flush) begin
              if_ok_q   <= 1'b1;
              if_inst_q <= mc_inst;
            end
          end else if (flush) begin
            mc_enable_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ok     = if_ok_q;
  assign if_inst   = if_inst_q;
  assign mc_enable = mc_enable_q;
  assign mc_pc     = mc_pc_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache with a mem_ctrl responder, a line-level
// reference model checked every cycle, and hand-computed fetch expectations.
module tb_inst_cache;

  localparam int IB    = 7;
  localparam int AW    = 32;
  localparam int LINES = 1 << IB;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        if_req  = 1'b0;
  logic [31:0] if_pc   = 32'h0;
  logic        flush   = 1'b0;
  logic [31:0] if_inst;
  logic        if_ok;
  logic [31:0] mc_pc;
  logic        mc_enable;
  logic [31:0] mc_inst = 32'h0;
  logic        mc_ok   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_cache #(.INDEX_BITS(IB), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_pc     (if_pc),
    .flush     (flush),
    .if_inst   (if_inst),
    .if_ok     (if_ok),
    .mc_pc     (mc_pc),
    .mc_enable (mc_enable),
    .mc_inst   (mc_inst),
    .mc_ok     (mc_ok)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // mem_ctrl stand-in: after mem_lat cycles of continuous enable, one-cycle
  // inst_ok pulse with mem_val; a dropped enable aborts the count.
  logic [31:0] mem_val = 32'h0;
  int          mem_lat = 6;
  int          mem_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      mc_ok   = 1'b0;
      mem_cnt = 0;
    end else if (mc_ok) begin
      mc_ok   = 1'b0;
      mem_cnt = 0;
    end else if (mc_enable) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        mc_ok   = 1'b1;
        mc_inst = mem_val;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Reference: each line remembers the full word address it holds.
  bit          m_valid [LINES];
  logic [29:0] m_waddr [LINES];
  logic [31:0] m_data  [LINES];
  bit          m_busy;
  logic [31:0] m_addr;
  logic        e_ok, e_en;
  logic [31:0] e_inst, e_pc;
  bit          model_live = 0;

  always @(posedge clk) begin : model
    bit resp;
    int idx;
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_busy = 0; e_ok = 0; e_en = 0; e_inst = 0; e_pc = 0;
      model_live = 1;
    end else if (model_live) begin
      resp = 0;
      if (!m_busy) begin
        if (if_req && !e_ok && !flush) begin
          idx = int'(if_pc[IB+1:2]);
          if (m_valid[idx] && m_waddr[idx] == if_pc[31:2]) begin
            resp   = 1;
            e_inst = m_data[idx];
          end else begin
            m_busy = 1; m_addr = if_pc; e_pc = if_pc; e_en = 1;
          end
        end
      end else if (mc_ok) begin
        idx = int'(m_addr[IB+1:2]);
        m_valid[idx] = 1; m_waddr[idx] = m_addr[31:2]; m_data[idx] = mc_inst;
        m_busy = 0; e_en = 0;
        if (!flush) begin
          resp   = 1;
          e_inst = mc_inst;
        end
      end else if (flush) begin
        m_busy = 0; e_en = 0;
      end
      e_ok = resp;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_live) begin
      check("if_ok", {31'b0, if_ok}, {31'b0, e_ok});
      check("mc_enable", {31'b0, mc_enable}, {31'b0, e_en});
      check("mc_pc", mc_pc, e_pc);
      if (e_ok) check("if_inst", if_inst, e_inst);
    end
  end

  // One IF fetch: hold request until if_ok, report latency in cycles.
  task automatic fetch(input logic [31:0] pc, output int cyc,
                       output logic [31:0] inst, output bit en_seen);
    @(negedge clk);
    if_req = 1'b1; if_pc = pc; cyc = 0; en_seen = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mc_enable) en_seen = 1;
    end while (!if_ok && cyc < 40);
    if (!if_ok) begin
      n_vec++; n_err++;
      $display("FAIL fetch_timeout: pc %h got no if_ok within %0d cycles", pc, cyc);
    end
    inst   = if_inst;
    if_req = 1'b0;
  endtask

  initial begin
    int          cyc, k;
    logic [31:0] inst;
    bit          en;

    repeat (2) @(negedge clk);
    check("rst_if_ok", {31'b0, if_ok}, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_mc_enable", {31'b0, mc_enable}, 32'h0);
    check("rst_mc_pc", mc_pc, 32'h0);
    rst = 1'b0;

    // Cold miss: 6-cycle memory wait plus the fill edge.
    mem_val = 32'h0000_0513;
    fetch(32'h0, cyc, inst, en);
    check("cold_latency", cyc, 32'd7);
    check("cold_inst", inst, 32'h0000_0513);
    check("cold_used_mem", {31'b0, en}, 32'h1);
    check("cold_en_low_at_ok", {31'b0, mc_enable}, 32'h0);

    // Hit: memory now holds different data, the cache must not use it.
    mem_val = 32'hDEAD_BEEF;
    fetch(32'h0, cyc, inst, en);
    check("hit_latency", cyc, 32'd1);
    check("hit_inst", inst, 32'h0000_0513);
    check("hit_no_mem", {31'b0, en}, 32'h0);

    // Flush on a would-be hit cycle suppresses the response.
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'h0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; if_req = 1'b0;
    check("flush_hit_no_ok", {31'b0, if_ok}, 32'h0);

    // Conflict on index 1.
    mem_val = 32'h1111_1111;
    fetch(32'h4, cyc, inst, en);
    check("conf_a_latency", cyc, 32'd7);
    check("conf_a_inst", inst, 32'h1111_1111);
    mem_val = 32'h2222_2222;
    fetch(32'h204, cyc, inst, en);
    check("conf_b_latency", cyc, 32'd7);
    check("conf_b_inst", inst, 32'h2222_2222);
    mem_val = 32'h3333_3333;
    fetch(32'h4, cyc, inst, en);
    check("conf_a2_latency", cyc, 32'd7);
    check("conf_a2_inst", inst, 32'h3333_3333);
    fetch(32'h0, cyc, inst, en);
    check("other_line_hit", inst, 32'h0000_0513);

    // Flush in the third wait cycle of a miss.
    mem_val = 32'h0AAA_0AAA;
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'h10; k = 0;
    do begin @(negedge clk); k++; end while (!mc_enable && k < 10);
    repeat (2) @(negedge clk);
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_miss_en_drop", {31'b0, mc_enable}, 32'h0);
    check("flush_miss_no_ok", {31'b0, if_ok}, 32'h0);
    repeat (8) @(negedge clk);
    mem_val = 32'h0BBB_0BBB;
    fetch(32'h10, cyc, inst, en);
    check("after_flush_miss_lat", cyc, 32'd7);
    check("after_flush_miss_inst", inst, 32'h0BBB_0BBB);

    // Flush in the same cycle as mc_ok: line fills, no response.
    mem_val = 32'h00A0_0093;
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'h20; k = 0;
    do begin @(negedge clk); k++; end while (!mc_ok && k < 20);
    if (!mc_ok) begin
      n_vec++; n_err++;
      $display("FAIL coinc_wait: mc_ok %b, want 1 within %0d cycles", mc_ok, k);
    end
    flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("coinc_no_ok", {31'b0, if_ok}, 32'h0);
    check("coinc_en_low", {31'b0, mc_enable}, 32'h0);
    mem_val = 32'hDEAD_BEEF;
    fetch(32'h20, cyc, inst, en);
    check("coinc_refetch_lat", cyc, 32'd1);
    check("coinc_refetch_inst", inst, 32'h00A0_0093);

    // Reset while a miss is outstanding.
    @(negedge clk);
    if_req = 1'b1; if_pc = 32'h40; k = 0;
    do begin @(negedge clk); k++; end while (!mc_enable && k < 10);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("rst_miss_en_drop", {31'b0, mc_enable}, 32'h0);
    check("rst_miss_pc", mc_pc, 32'h0);
    rst = 1'b0;
    mem_val = 32'h0000_0055;
    fetch(32'h0, cyc, inst, en);
    check("post_rst_latency", cyc, 32'd7);
    check("post_rst_inst", inst, 32'h0000_0055);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
